muldiv_unit: RTL

- Parametrised iterative multiply/divide unit that produces the HI/LO results for MULT, MULTU, DIV and DIVU.
- Successor to the fixed 32-bit mult/div control blocks that feed the HI/LO muxes in the multicycle CPU.
- Generalised operand width; signed and unsigned modes; start/busy/done handshake; divide-by-zero flag; internal HI/LO holding registers.
- The CPU controller pulses start and then waits on done before writing HI/LO or reading them out.

---
 rtl/muldiv_unit_if.sv | 38 +++
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: start/busy/done handshake and HI/LO result bus.
// MULDIV_HILO_WR_EN adds the hi_wr/lo_wr/wr_data write port.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_HILO_WR_EN
    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output start, op, a, b, hi_wr, lo_wr, wr_data,
        input  busy, done, div_zero, hi, lo
    );
    modport slave (
        input  start, op, a, b, hi_wr, lo_wr, wr_data,
        output busy, done, div_zero, hi, lo
    );
`else
    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );
    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
`endif
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU, one bit per cycle, HI/LO regs.
// Optional MTHI/MTLO write port when MULDIV_HILO_WR_EN is defined.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clock,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               is_div;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Operand magnitudes, step adders and sign fix-up of the raw result.
    always_comb begin
        is_div   = op_q[1];
        neg_a    = ~op_q[0] & a_q[WIDTH-1];
        neg_b    = ~op_q[0] & b_q[WIDTH-1];
        abs_a    = neg_a ? -a_q : a_q;
        abs_b    = neg_b ? -b_q : b_q;
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        // Top WIDTH+1 bits after the left shift, minus the divisor.
        sub_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
        fix_hi   = acc_q[2*WIDTH-1:WIDTH];
        fix_lo   = acc_q[WIDTH-1:0];
        if (is_div) begin
            if (rem_neg_q) fix_hi = -acc_q[2*WIDTH-1:WIDTH];
            if (res_neg_q) fix_lo = -acc_q[WIDTH-1:0];
        end else if (res_neg_q) begin
            {fix_hi, fix_lo} = -acc_q;
        end
    end

    // Next-state and datapath update for the IDLE/PREP/RUN/FIX/DONE sequence.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = PREP;
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                end
`ifdef MULDIV_HILO_WR_EN
                if (bus.hi_wr) hi_d = bus.wr_data;
                if (bus.lo_wr) lo_d = bus.wr_data;
`endif
            end
            PREP: begin
                res_neg_d = neg_a ^ neg_b;
                rem_neg_d = neg_a;
                acc_d     = {{WIDTH{1'b0}}, abs_a};
                b_d       = abs_b;
                cnt_d     = '0;
                if (is_div && (b_q == '0)) begin
                    state_d = DONE;
                    dz_d    = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (is_div) begin
                    // Restoring step: keep the subtraction only if it did not borrow.
                    if (!sub_diff[WIDTH])
                        acc_d = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end else begin
                    // Shift-add: carry out of the add shifts into the top bit.
                    if (acc_q[0])
                        acc_d = {add_sum, acc_q[WIDTH-1:1]};
                    else
                        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
                else cnt_d = cnt_q + CW'(1);
            end
            FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == PREP) || (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // All state and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
